// File: rtl/instr_mem_loader.sv
// Instruction memory with a one-cycle registered fetch port and an
// auto-incrementing burst loader; fetches are only accepted while no burst is active.
module instr_mem_loader #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 2048,
    parameter int CNT_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_err,

    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    output logic              load_err,
    output logic [CNT_W-1:0]  load_count,
    output logic              busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] PTR_MAX = '1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_LOAD = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic              is_idle;
    logic              is_load;
    logic              fetch_acc;
    logic              fetch_in_range;
    logic              start_acc;
    logic              beat_acc;
    logic              ptr_in_range;
    logic              wr_en;
    logic              rd_en;

    logic              fetch_valid_q, fetch_valid_d;
    logic              fetch_err_q,   fetch_err_d;
    logic              load_done_q,   load_done_d;
    logic              load_err_q,    load_err_d;
    logic [CNT_W-1:0]  load_count_q,  load_count_d;
    logic [CNT_W-1:0]  ptr_q,         ptr_d;
    logic [DATA_W-1:0] rd_data_q;

    logic [DATA_W-1:0] mem [DEPTH];

    assign is_idle        = (state_q == S_IDLE);
    assign is_load        = (state_q == S_LOAD);
    assign fetch_acc      = fetch_req & is_idle;
    assign fetch_in_range = (CNT_W'(fetch_addr) < DEPTH_C);
    assign start_acc      = load_start & is_idle;
    assign beat_acc       = load_valid & is_load;
    assign ptr_in_range   = (ptr_q < DEPTH_C);
    assign wr_en          = beat_acc & ptr_in_range;
    assign rd_en          = fetch_acc & fetch_in_range;

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (load_start) state_d = S_LOAD;
            S_LOAD: if (load_valid && load_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs decoded straight from the state register
    always_comb begin
        fetch_ready = is_idle;
        load_ready  = is_load;
        busy        = is_load;
    end

    // Next values for the fetch result flags and the loader bookkeeping.
    always_comb begin
        fetch_valid_d = fetch_acc;
        fetch_err_d   = fetch_acc & ~fetch_in_range;
        load_done_d   = beat_acc & load_last;
        load_err_d    = load_err_q;
        load_count_d  = load_count_q;
        ptr_d         = ptr_q;
        if (start_acc) begin
            ptr_d        = CNT_W'(load_base);
            load_count_d = '0;
            load_err_d   = 1'b0;
        end else if (beat_acc) begin
            load_count_d = load_count_q + 1'b1;
            // Saturate so a runaway burst can never wrap back onto low words.
            if (ptr_q != PTR_MAX) begin
                ptr_d = ptr_q + 1'b1;
            end
            if (!ptr_in_range) begin
                load_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            load_done_q   <= 1'b0;
            load_err_q    <= 1'b0;
            load_count_q  <= '0;
            ptr_q         <= '0;
        end else begin
            fetch_valid_q <= fetch_valid_d;
            fetch_err_q   <= fetch_err_d;
            load_done_q   <= load_done_d;
            load_err_q    <= load_err_d;
            load_count_q  <= load_count_d;
            ptr_q         <= ptr_d;
        end
    end

    // Storage array with a registered read; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ptr_q[IDX_W-1:0]] <= load_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[fetch_addr[IDX_W-1:0]];
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign fetch_err   = fetch_err_q;
    assign fetch_data  = (fetch_valid_q && !fetch_err_q) ? rd_data_q : '0;
    assign load_done   = load_done_q;
    assign load_err    = load_err_q;
    assign load_count  = load_count_q;

endmodule
